// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage next-PC controller.
// Holds the FSM state encoding, mux select encodings and the default reset PC.
package pc_sequencer_pkg;

   localparam int          PC_W_DEF     = 32;
   localparam int          TGT_W_DEF    = 26;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   localparam logic PC_SEL_SEQ = 1'b0;
   localparam logic PC_SEL_JMP = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake: request plus address out, acknowledge back.
// The sequencer is the master; the memory (or a bench model) is the slave.
interface pc_sequencer_if #(
   parameter int PC_W = 32
) ();

   logic            req;
   logic [PC_W-1:0] addr;
   logic            ack;

   modport master (output req, output addr, input ack);
   modport slave  (input req, input addr, output ack);

endinterface

// File: rtl/pc_sequencer_mux.sv
// Existing two-input next-PC mux: sel=0 passes in0 (PC+4), sel=1 passes in1 (target).
module pc_sequencer_mux #(
   parameter int W = 32
) (
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   input  logic         sel,
   output logic [W-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC controller: owns the PC, runs the imem request/ack handshake
// and folds in stalls and jumps, including jumps that arrive while a fetch is outstanding.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              TGT_W    = TGT_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               jump_valid,
   input  logic [TGT_W-1:0]   jump_target,
   pc_sequencer_if.master     imem,
   output logic               pc_sel,
   output logic [PC_W-1:0]    pc,
   output logic               instr_valid
);

   state_t             state_r;
   state_t             state_s;
   logic [PC_W-1:0]    pc_r;
   logic               pend_r;
   logic               pend_s;
   logic [TGT_W-1:0]   pend_tgt_r;
   logic [TGT_W-1:0]   pend_tgt_s;
   logic [TGT_W-1:0]   tgt_s;
   logic               pc_load_s;
   logic               pc_sel_s;
   logic               instr_valid_s;
   logic [PC_W-1:0]    seq_pc_s;
   logic [PC_W-1:0]    jmp_pc_s;
   logic [PC_W-1:0]    next_pc_s;

   assign seq_pc_s = pc_r + PC_W'(32'd4);
   assign jmp_pc_s = {{(PC_W-TGT_W){1'b0}}, tgt_s};

   pc_sequencer_mux #(.W(PC_W)) u_mux (
      .in0 (seq_pc_s),
      .in1 (jmp_pc_s),
      .sel (pc_sel_s),
      .out (next_pc_s)
   );

   // Next-state, pending-jump and PC-load decisions.
   always_comb begin
      state_s       = state_r;
      pend_s        = pend_r;
      pend_tgt_s    = pend_tgt_r;
      tgt_s         = pend_tgt_r;
      pc_load_s     = 1'b0;
      pc_sel_s      = PC_SEL_SEQ;
      instr_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (!stall) begin
               state_s = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (imem.ack) begin
               pc_load_s = 1'b1;
               // A jump seen this cycle is newer than any pending one, so it wins.
               if (jump_valid || pend_r) begin
                  pc_sel_s = PC_SEL_JMP;
                  pend_s   = 1'b0;
                  if (jump_valid) begin
                     tgt_s = jump_target;
                  end else begin
                     tgt_s = pend_tgt_r;
                  end
               end else begin
                  instr_valid_s = 1'b1;
               end
               if (stall) begin
                  state_s = HOLD;
               end else begin
                  state_s = REQ;
               end
            end else if (jump_valid) begin
               pend_s     = 1'b1;
               pend_tgt_s = jump_target;
            end else begin
               pend_s = pend_r;
            end
         end
         HOLD: begin
            if (jump_valid) begin
               pc_load_s = 1'b1;
               pc_sel_s  = PC_SEL_JMP;
               tgt_s     = jump_target;
            end else begin
               pc_load_s = 1'b0;
            end
            if (stall) begin
               state_s = HOLD;
            end else begin
               state_s = REQ;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, PC and pending-jump registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         pc_r       <= RESET_PC;
         pend_r     <= 1'b0;
         pend_tgt_r <= '0;
      end else begin
         state_r    <= state_s;
         pend_r     <= pend_s;
         pend_tgt_r <= pend_tgt_s;
         if (pc_load_s) begin
            pc_r <= next_pc_s;
         end else begin
            pc_r <= pc_r;
         end
      end
   end

   assign imem.req    = (state_r == REQ);
   assign imem.addr   = pc_r;
   assign pc          = pc_r;
   assign pc_sel      = pc_sel_s;
   assign instr_valid = instr_valid_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: two instances (reset PC 0 and reset PC near the
// top of the address space) driven through fetch, wait, jump, stall and reset scenarios.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        jv;
   logic [25:0] jt;
   logic        pc_sel0, iv0, pc_sel1, iv1;
   logic [31:0] pc0, pc1;
   int          n_assert = 0;
   int          n_fail   = 0;

   pc_sequencer_if #(.PC_W(32)) bus0 ();
   pc_sequencer_if #(.PC_W(32)) bus1 ();

   assign bus1.ack = 1'b1;

   pc_sequencer #(.PC_W(32), .TGT_W(26), .RESET_PC(32'h0000_0000)) u_dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .jump_valid  (jv),
      .jump_target (jt),
      .imem        (bus0),
      .pc_sel      (pc_sel0),
      .pc          (pc0),
      .instr_valid (iv0)
   );

   pc_sequencer #(.PC_W(32), .TGT_W(26), .RESET_PC(32'hFFFF_FFF8)) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (1'b0),
      .jump_valid  (1'b0),
      .jump_target (26'h0),
      .imem        (bus1),
      .pc_sel      (pc_sel1),
      .pc          (pc1),
      .instr_valid (iv1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] wrap_exp [4];
      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;
      wrap_exp[3] = 32'h0000_0004;

      rst_n = 1'b0; stall = 1'b0; jv = 1'b0; jt = 26'h0; bus0.ack = 1'b1;
      #12;
      chk("rst_req",    {31'd0, bus0.req}, 32'd0);
      chk("rst_pc",     pc0, 32'h0000_0000);
      chk("rst_iv",     {31'd0, iv0}, 32'd0);
      chk("rst_pcsel",  {31'd0, pc_sel0}, 32'd0);
      chk("rst_pc1",    pc1, 32'hFFFF_FFF8);

      @(negedge clk); rst_n = 1'b1; #2;
      chk("idle_req",   {31'd0, bus0.req}, 32'd0);

      // Free run with ack tied high on both instances.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #2;
         chk("run_addr",  bus0.addr, 32'(k * 4));
         chk("run_req",   {31'd0, bus0.req}, 32'd1);
         chk("run_iv",    {31'd0, iv0}, 32'd1);
         chk("run_pcsel", {31'd0, pc_sel0}, 32'd0);
         chk("wrap_addr", bus1.addr, wrap_exp[k]);
         chk("wrap_iv",   {31'd0, iv1}, 32'd1);
      end

      // Delayed ack at 0x10 with a jump in the first wait cycle.
      @(negedge clk); bus0.ack = 1'b0; jv = 1'b1; jt = 26'h0000100; #2;
      chk("w1_addr",  bus0.addr, 32'h10);
      chk("w1_req",   {31'd0, bus0.req}, 32'd1);
      chk("w1_iv",    {31'd0, iv0}, 32'd0);
      chk("w1_pcsel", {31'd0, pc_sel0}, 32'd0);
      @(negedge clk); jv = 1'b0; #2;
      chk("w2_addr",  bus0.addr, 32'h10);
      @(negedge clk); #2;
      chk("w3_addr",  bus0.addr, 32'h10);
      @(negedge clk); bus0.ack = 1'b1; #2;
      chk("jack_iv",    {31'd0, iv0}, 32'd0);
      chk("jack_pcsel", {31'd0, pc_sel0}, 32'd1);

      // Two jumps during one wait: last one wins.
      @(negedge clk); bus0.ack = 1'b0; jv = 1'b1; jt = 26'h40; #2;
      chk("j2_addr",  bus0.addr, 32'h100);
      @(negedge clk); jt = 26'h80; #2;
      chk("j2_pcsel", {31'd0, pc_sel0}, 32'd0);
      @(negedge clk); jv = 1'b0; bus0.ack = 1'b1; #2;
      chk("j2_iv",    {31'd0, iv0}, 32'd0);
      chk("j2_ack",   {31'd0, pc_sel0}, 32'd1);

      // Jump and ack in the same cycle: jump wins.
      @(negedge clk); jv = 1'b1; jt = 26'h20; #2;
      chk("j2_next",  bus0.addr, 32'h80);
      chk("same_iv",  {31'd0, iv0}, 32'd0);
      chk("same_sel", {31'd0, pc_sel0}, 32'd1);

      // Stall at the ack of 0x20, then a jump while held.
      @(negedge clk); jv = 1'b0; stall = 1'b1; #2;
      chk("st_addr",  bus0.addr, 32'h20);
      chk("st_iv",    {31'd0, iv0}, 32'd1);
      chk("st_sel",   {31'd0, pc_sel0}, 32'd0);
      @(negedge clk); #2;
      chk("h1_req",   {31'd0, bus0.req}, 32'd0);
      chk("h1_pc",    pc0, 32'h24);
      chk("h1_iv",    {31'd0, iv0}, 32'd0);
      @(negedge clk); #2;
      chk("h2_pc",    pc0, 32'h24);
      @(negedge clk); jv = 1'b1; jt = 26'h200; #2;
      chk("hj_sel",   {31'd0, pc_sel0}, 32'd1);
      chk("hj_req",   {31'd0, bus0.req}, 32'd0);
      @(negedge clk); jv = 1'b0; #2;
      chk("hj_pc",    pc0, 32'h200);
      chk("hj_sel2",  {31'd0, pc_sel0}, 32'd0);
      @(negedge clk); stall = 1'b0; bus0.ack = 1'b0; #2;
      chk("hr_req",   {31'd0, bus0.req}, 32'd0);
      @(negedge clk); #2;
      chk("f2_req",   {31'd0, bus0.req}, 32'd1);
      chk("f2_addr",  bus0.addr, 32'h200);

      // Stall rising mid-request does not withdraw the fetch.
      @(negedge clk); stall = 1'b1; #2;
      chk("sr_req",   {31'd0, bus0.req}, 32'd1);
      @(negedge clk); #2;
      chk("sr_req2",  {31'd0, bus0.req}, 32'd1);
      chk("sr_addr",  bus0.addr, 32'h200);
      @(negedge clk); stall = 1'b0; bus0.ack = 1'b1; jv = 1'b1; jt = 26'h2C; #2;
      chk("r_sel",    {31'd0, pc_sel0}, 32'd1);
      @(negedge clk); jv = 1'b0; #2;
      chk("r_addr",   bus0.addr, 32'h2C);
      chk("r_iv",     {31'd0, iv0}, 32'd1);

      // Async reset mid-fetch with a jump pending.
      @(negedge clk); bus0.ack = 1'b0; jv = 1'b1; jt = 26'h300; #2;
      chk("pr_addr",  bus0.addr, 32'h30);
      chk("pr_req",   {31'd0, bus0.req}, 32'd1);
      @(negedge clk); jv = 1'b0; #1; rst_n = 1'b0; #1;
      chk("ar_req",   {31'd0, bus0.req}, 32'd0);
      chk("ar_pc",    pc0, 32'h0);
      @(negedge clk); rst_n = 1'b1; bus0.ack = 1'b1; #2;
      chk("ar_idle",  {31'd0, bus0.req}, 32'd0);
      @(negedge clk); #2;
      chk("ar_addr0", bus0.addr, 32'h0);
      chk("ar_iv0",   {31'd0, iv0}, 32'd1);
      chk("ar_sel0",  {31'd0, pc_sel0}, 32'd0);
      @(negedge clk); #2;
      chk("ar_addr4", bus0.addr, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
